// File: rtl/irq_inj_pkg.sv
// Shared types and helpers for the programmable PC-triggered interrupt injector.
package irq_inj_pkg;

    localparam int CNT_W = 8;
    localparam int DLY_W = 8;
    localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h7f20;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        ASSERT,
        REARM
    } state_e;

    typedef struct packed {
        logic [31:0]      pc;
        logic [CNT_W-1:0] count;
        logic [DLY_W-1:0] delay;
        logic             pulse;
    } trig_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/irq_trig_match.sv
// Parallel PC comparators over the trigger table with lowest-index priority.
module irq_trig_match
    import irq_inj_pkg::*;
#(
    parameter int NUM_TRIG = 4,
    parameter int IDX_W    = 2
) (
    input  logic [31:0]      pc,
    input  trig_entry_t      entries [NUM_TRIG],
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx
);

    always_comb begin
        // NOTE: outputs get defaults before the loop so no path leaves them unassigned, which would infer a latch.
        hit     = 1'b0;
        hit_idx = '0;
        // Walk downwards so the lowest matching index is the last one written.
        for (int i = NUM_TRIG - 1; i >= 0; i--) begin
            if (entries[i].count != '0 && word_align(pc) == word_align(entries[i].pc)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_inject_ctrl.sv
// Interrupt injector: fires the CPU interrupt when the PC hits a programmed target,
// holding it until ack (level) or for a fixed pulse, with per-entry count and delay.
module irq_inject_ctrl
    import irq_inj_pkg::*;
#(
    parameter int          NUM_TRIG  = 4,
    parameter int          PULSE_LEN = 4,
    parameter int          ACK_TMO   = 1024,
    parameter logic [31:0] ACK_ADDR  = ACK_ADDR_DEFAULT,
    localparam int         IDX_W     = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [31:0]      cfg_pc,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic             cfg_pulse,
    input  logic [31:0]      macroscopic_pc,
    input  logic [31:0]      m_int_addr,
    input  logic [3:0]       m_int_byteen,
    output logic             interrupt,
    output logic [IDX_W-1:0] irq_idx,
    output logic             busy,
    output logic [15:0]      fire_total,
    output logic             ack_tmo_err
);

    localparam int TMO_W  = $clog2(ACK_TMO + 1);
    localparam int PLS_W  = $clog2(PULSE_LEN + 1);
    localparam int TMR_A  = (TMO_W > PLS_W) ? TMO_W : PLS_W;
    localparam int TMR_W  = (TMR_A > DLY_W) ? TMR_A : DLY_W;

    trig_entry_t      entries_q [NUM_TRIG];
    trig_entry_t      entries_d [NUM_TRIG];
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pulse_q, pulse_d;
    logic [31:0]      tgt_q, tgt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             interrupt_q, interrupt_d;
    logic [15:0]      fire_total_q, fire_total_d;
    logic             ack_tmo_err_q, ack_tmo_err_d;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             ack;

    irq_trig_match #(
        .NUM_TRIG (NUM_TRIG),
        .IDX_W    (IDX_W)
    ) u_match (
        .pc      (macroscopic_pc),
        .entries (entries_q),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    assign ack = (|m_int_byteen) && (word_align(m_int_addr) == ACK_ADDR);

    always_comb begin
        entries_d     = entries_q;
        state_d       = state_q;
        idx_d         = idx_q;
        pulse_d       = pulse_q;
        tgt_d         = tgt_q;
        tmr_d         = tmr_q;
        interrupt_d   = interrupt_q;
        fire_total_d  = fire_total_q;
        ack_tmo_err_d = ack_tmo_err_q;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    idx_d   = hit_idx;
                    pulse_d = entries_q[hit_idx].pulse;
                    tgt_d   = word_align(entries_q[hit_idx].pc);
                    tmr_d   = TMR_W'(entries_q[hit_idx].delay);
                    state_d = (entries_q[hit_idx].delay == '0) ? ASSERT : DELAY;
                end
            end
            DELAY: begin
                if (tmr_q <= TMR_W'(1)) state_d = ASSERT;
                else                    tmr_d   = tmr_q - TMR_W'(1);
            end
            ASSERT: begin
                // interrupt still low means this is the first ASSERT cycle: fire now.
                if (!interrupt_q) begin
                    interrupt_d = 1'b1;
                    if (fire_total_q != 16'hffff) fire_total_d = fire_total_q + 16'd1;
                    if (entries_q[idx_q].count != '0 && entries_q[idx_q].count != '1)
                        entries_d[idx_q].count = entries_q[idx_q].count - CNT_W'(1);
                    tmr_d = pulse_q ? TMR_W'(PULSE_LEN) : TMR_W'(ACK_TMO);
                end else if (ack) begin
                    interrupt_d = 1'b0;
                    state_d     = REARM;
                end else if (tmr_q == TMR_W'(1)) begin
                    interrupt_d = 1'b0;
                    state_d     = REARM;
                    if (!pulse_q) ack_tmo_err_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            REARM: begin
                if (word_align(macroscopic_pc) != tgt_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Applied last so a config write beats the fire-time decrement on the same entry.
        if (cfg_we) begin
            entries_d[cfg_idx] = '{pc: cfg_pc, count: cfg_count, delay: cfg_delay, pulse: cfg_pulse};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop captures the pre-edge values computed above.
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            pulse_q       <= 1'b0;
            tgt_q         <= '0;
            tmr_q         <= '0;
            interrupt_q   <= 1'b0;
            fire_total_q  <= '0;
            ack_tmo_err_q <= 1'b0;
            // NOTE: the trigger table is reset explicitly; a stale entry surviving reset would fire on an old PC.
            for (int i = 0; i < NUM_TRIG; i++) entries_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pulse_q       <= pulse_d;
            tgt_q         <= tgt_d;
            tmr_q         <= tmr_d;
            interrupt_q   <= interrupt_d;
            fire_total_q  <= fire_total_d;
            ack_tmo_err_q <= ack_tmo_err_d;
            entries_q     <= entries_d;
        end
    end

    assign interrupt   = interrupt_q;
    assign irq_idx     = idx_q;
    assign busy        = (state_q != IDLE);
    assign fire_total  = fire_total_q;
    assign ack_tmo_err = ack_tmo_err_q;

endmodule

// File: tb/tb_irq_inject_ctrl.sv
// Scoreboard bench: stimulus queues each expected interrupt episode, a monitor
// measures every real episode (rise cycle, index, total, width) and compares.
module tb_irq_inject_ctrl;

    localparam int NUM_TRIG  = 4;
    localparam int PULSE_LEN = 4;
    localparam int ACK_TMO   = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_pc;
    logic [7:0]  cfg_count;
    logic [7:0]  cfg_delay;
    logic        cfg_pulse;
    logic [31:0] macroscopic_pc;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic        interrupt;
    logic [1:0]  irq_idx;
    logic        busy;
    logic [15:0] fire_total;
    logic        ack_tmo_err;

    irq_inject_ctrl #(
        .NUM_TRIG  (NUM_TRIG),
        .PULSE_LEN (PULSE_LEN),
        .ACK_TMO   (ACK_TMO),
        .ACK_ADDR  (32'h7f20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_pc         (cfg_pc),
        .cfg_count      (cfg_count),
        .cfg_delay      (cfg_delay),
        .cfg_pulse      (cfg_pulse),
        .macroscopic_pc (macroscopic_pc),
        .m_int_addr     (m_int_addr),
        .m_int_byteen   (m_int_byteen),
        .interrupt      (interrupt),
        .irq_idx        (irq_idx),
        .busy           (busy),
        .fire_total     (fire_total),
        .ack_tmo_err    (ack_tmo_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int total;
        int rise;
        int width;
    } fire_t;

    fire_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int idx, input logic [31:0] pc, input int count,
                       input int delay, input bit pulse);
        cfg_we    = 1'b1;
        cfg_idx   = idx[1:0];
        cfg_pc    = pc;
        cfg_count = count[7:0];
        cfg_delay = delay[7:0];
        cfg_pulse = pulse;
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic push_fire(input int idx, input int total, input int rise, input int width);
        fire_t e;
        e.idx   = idx;
        e.total = total;
        e.rise  = rise;
        e.width = width;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison set per interrupt episode, taken on the falling edge of clk.
    initial begin : monitor
        bit    prev;
        int    rise_c, rise_i, rise_t, width;
        fire_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (interrupt === 1'b1) begin
                if (!prev) begin
                    rise_c = cyc;
                    rise_i = int'(irq_idx);
                    rise_t = int'(fire_total);
                    width  = 0;
                end
                width++;
                prev = 1'b1;
            end else if (prev) begin
                prev = 1'b0;
                check("fire_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("fire_rise_cycle", rise_c, e.rise);
                    check("fire_irq_idx", rise_i, e.idx);
                    check("fire_total_at_rise", rise_t, e.total);
                    check("fire_width", width, e.width);
                end
            end
        end
    end

    initial begin : stimulus
        int t;
        reset          = 1'b1;
        cfg_we         = 1'b0;
        cfg_idx        = '0;
        cfg_pc         = '0;
        cfg_count      = '0;
        cfg_delay      = '0;
        cfg_pulse      = 1'b0;
        macroscopic_pc = 32'h0000_3100;
        m_int_addr     = '0;
        m_int_byteen   = '0;
        tick(3);
        check("rst_interrupt", int'(interrupt), 0);
        check("rst_irq_idx", int'(irq_idx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fire_total", int'(fire_total), 0);
        check("rst_ack_tmo_err", int'(ack_tmo_err), 0);
        reset = 1'b0;
        tick(1);

        // 1: level mode, delay 0, ack via sub-word write; low PC bits ignored.
        cfg(0, 32'h3010, 1, 0, 1'b0);
        macroscopic_pc = 32'h3012;
        t = cyc;
        push_fire(0, 1, t + 2, 2);
        tick(3);
        m_int_addr   = 32'h7f22;
        m_int_byteen = 4'b0100;
        tick(1);
        m_int_addr   = '0;
        m_int_byteen = '0;
        tick(2);
        macroscopic_pc = 32'h3000;
        tick(3);
        macroscopic_pc = 32'h3010;
        tick(6);
        check("t1_fire_total", int'(fire_total), 1);
        check("t1_busy_after_revisit", int'(busy), 0);
        macroscopic_pc = 32'h3100;
        tick(2);

        // 2: pulse mode, count 3, five visits -> three pulses.
        cfg(1, 32'h3020, 3, 0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            macroscopic_pc = 32'h3020;
            t = cyc;
            if (k < 3) push_fire(1, 2 + k, t + 2, PULSE_LEN);
            tick(8);
            macroscopic_pc = 32'h3100;
            tick(3);
        end
        check("t2_fire_total", int'(fire_total), 4);

        // 3: priority between entries on the same PC.
        cfg(0, 32'h3040, 2, 0, 1'b1);
        cfg(2, 32'h3040, 1, 0, 1'b1);
        macroscopic_pc = 32'h3040;
        t = cyc;
        push_fire(0, 5, t + 2, PULSE_LEN);
        tick(8);
        check("t3_irq_idx_low", int'(irq_idx), 0);
        macroscopic_pc = 32'h3100;
        tick(3);
        cfg(0, 32'h3040, 0, 0, 1'b1);
        macroscopic_pc = 32'h3040;
        t = cyc;
        push_fire(2, 6, t + 2, PULSE_LEN);
        tick(8);
        check("t3_irq_idx_next", int'(irq_idx), 2);
        macroscopic_pc = 32'h3100;
        tick(3);

        // 4: delay 5 with PC held; rewrite the active entry mid-delay (latched mode applies).
        cfg(3, 32'h3050, 2, 5, 1'b1);
        macroscopic_pc = 32'h3050;
        t = cyc;
        push_fire(3, 7, t + 7, PULSE_LEN);
        tick(3);
        cfg(3, 32'h3050, 0, 0, 1'b0);
        tick(16);
        check("t4_busy_rearm", int'(busy), 1);
        macroscopic_pc = 32'h3100;
        tick(3);
        check("t4_busy_idle", int'(busy), 0);
        macroscopic_pc = 32'h3050;
        tick(6);
        macroscopic_pc = 32'h3100;
        tick(2);

        // 5: level timeout; config write collides with the fire-time decrement and wins.
        cfg(0, 32'h3060, 1, 0, 1'b0);
        macroscopic_pc = 32'h3060;
        t = cyc;
        push_fire(0, 8, t + 2, ACK_TMO);
        tick(1);
        cfg(0, 32'h3060, 5, 0, 1'b0);
        tick(1028);
        check("t5_ack_tmo_err", int'(ack_tmo_err), 1);
        check("t5_interrupt_low", int'(interrupt), 0);
        check("t5_busy_rearm", int'(busy), 1);
        macroscopic_pc = 32'h3100;
        tick(2);
        check("t5_busy_idle", int'(busy), 0);
        macroscopic_pc = 32'h3060;
        t = cyc;
        push_fire(0, 9, t + 2, 4);
        tick(3);
        m_int_addr   = 32'h7f20;
        m_int_byteen = 4'b0000;
        tick(2);
        m_int_byteen = 4'b0001;
        tick(1);
        m_int_addr   = '0;
        m_int_byteen = '0;
        macroscopic_pc = 32'h3100;
        tick(3);
        check("t5_err_sticky", int'(ack_tmo_err), 1);

        // 6: reset while asserting clears everything, including the trigger table.
        cfg(2, 32'h3070, 255, 0, 1'b0);
        macroscopic_pc = 32'h3070;
        t = cyc;
        push_fire(2, 10, t + 2, 2);
        tick(3);
        reset = 1'b1;
        tick(1);
        check("t6_interrupt", int'(interrupt), 0);
        check("t6_irq_idx", int'(irq_idx), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_fire_total", int'(fire_total), 0);
        check("t6_ack_tmo_err", int'(ack_tmo_err), 0);
        reset = 1'b0;
        tick(5);
        macroscopic_pc = 32'h3010;
        tick(4);
        macroscopic_pc = 32'h3060;
        tick(4);
        check("t6_no_refire_total", int'(fire_total), 0);
        check("t6_no_refire_busy", int'(busy), 0);

        tick(5);
        check("pending_fires", exp_q.size(), 0);
        check("interrupt_idle_end", int'(interrupt), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
